// File: rtl/ysyx_25040101_mc_ctrl_pkg.sv
// Shared constants for the nebula multi-cycle controller: opcodes, immediate
// one-hots, ALU/WB/PC select codes, FSM state encoding and the decode bundle.
package ysyx_25040101_mc_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic [4:0] IMM_NONE = 5'b00000;
  localparam logic [4:0] IMM_I    = 5'b10000;
  localparam logic [4:0] IMM_S    = 5'b01000;
  localparam logic [4:0] IMM_B    = 5'b00100;
  localparam logic [4:0] IMM_U    = 5'b00010;
  localparam logic [4:0] IMM_J    = 5'b00001;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_CPB  = 4'd10;  // pass src B through (LUI)
  localparam logic [3:0] ALU_EQ   = 4'd11;
  localparam logic [3:0] ALU_NE   = 4'd12;
  localparam logic [3:0] ALU_GE   = 4'd13;
  localparam logic [3:0] ALU_GEU  = 4'd14;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_IMM = 2'b01;
  localparam logic [1:0] PC_SEL_ALU = 2'b10;

  typedef enum logic [1:0] {PK_SEQ, PK_JAL, PK_BR, PK_JALR} pc_kind_e;

  typedef enum logic [3:0] {
    S_RST, S_F_REQ, S_F_WAIT, S_DEC, S_EXE, S_M_REQ, S_M_WAIT, S_WB, S_HALT
  } state_e;

  typedef struct packed {
    logic [4:0] imm_type;
    logic [3:0] alu_op;
    logic       srca_pc;
    logic       srcb_imm;
    logic       rf_we;
    logic [1:0] wb_sel;
    pc_kind_e   pc_kind;
    logic       is_mem;
    logic       is_store;
    logic       illegal;
    logic       ebreak;
  } dec_t;

  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040101_mc_ctrl_idec.sv
// Combinational instruction decoder: IR -> control bundle consumed by the FSM.
module ysyx_25040101_idec
  import ysyx_25040101_mc_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b5;

  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign f7b5 = inst[30];

  // Opcodes with inst[1:0] != 2'b11 never match below, so they fall into illegal.
  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_ADD;
    dec.pc_kind = PK_SEQ;
    case (opc)
      OPC_LUI: begin
        dec.imm_type = IMM_U; dec.alu_op = ALU_CPB; dec.srcb_imm = 1'b1; dec.rf_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm_type = IMM_U; dec.srca_pc = 1'b1; dec.srcb_imm = 1'b1; dec.rf_we = 1'b1;
      end
      OPC_JAL: begin
        dec.imm_type = IMM_J; dec.srca_pc = 1'b1; dec.srcb_imm = 1'b1; dec.rf_we = 1'b1;
        dec.wb_sel = WB_PC4; dec.pc_kind = PK_JAL;
      end
      OPC_JALR: begin
        dec.imm_type = IMM_I; dec.srcb_imm = 1'b1; dec.rf_we = 1'b1;
        dec.wb_sel = WB_PC4; dec.pc_kind = PK_JALR;
      end
      OPC_BRANCH: begin
        dec.imm_type = IMM_B; dec.pc_kind = PK_BR;
        case (f3)
          3'b001:  dec.alu_op = ALU_NE;
          3'b100:  dec.alu_op = ALU_SLT;
          3'b101:  dec.alu_op = ALU_GE;
          3'b110:  dec.alu_op = ALU_SLTU;
          3'b111:  dec.alu_op = ALU_GEU;
          default: dec.alu_op = ALU_EQ;
        endcase
      end
      OPC_LOAD: begin
        dec.imm_type = IMM_I; dec.srcb_imm = 1'b1; dec.rf_we = 1'b1;
        dec.wb_sel = WB_MEM; dec.is_mem = 1'b1;
      end
      OPC_STORE: begin
        dec.imm_type = IMM_S; dec.srcb_imm = 1'b1; dec.is_mem = 1'b1; dec.is_store = 1'b1;
      end
      OPC_OPIMM: begin
        dec.imm_type = IMM_I; dec.srcb_imm = 1'b1; dec.rf_we = 1'b1;
        dec.alu_op = arith_op(f3, f7b5 && (f3 == 3'b101));
      end
      OPC_OP: begin
        dec.rf_we = 1'b1; dec.alu_op = arith_op(f3, f7b5);
      end
      OPC_SYSTEM: begin
        // Only ebreak is meaningful; everything else retires as a nop.
        dec.imm_type = IMM_I; dec.srcb_imm = 1'b1; dec.ebreak = (inst == EBREAK_INST);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_25040101_mc_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback; one instruction in flight.
module ysyx_25040101_mc_ctrl
  import ysyx_25040101_mc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid_o,
  input  logic        ifu_req_ready_i,
  input  logic        ifu_rsp_valid_i,
  input  logic [31:0] ifu_rsp_inst_i,
  input  logic        ifu_rsp_err_i,
  output logic [31:0] inst_o,
  output logic [4:0]  imm_type_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_srca_pc_o,
  output logic        alu_srcb_imm_o,
  input  logic        branch_taken_i,
  output logic        lsu_req_valid_o,
  input  logic        lsu_req_ready_i,
  output logic        lsu_we_o,
  output logic [1:0]  lsu_size_o,
  input  logic        lsu_rsp_valid_i,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        halt_o,
  output logic        trap_o
);

  state_e      state, state_nx;
  logic [31:0] ir;
  logic        taken, halt, trap;
  logic        dec_act;
  dec_t        dec;

  ysyx_25040101_idec u_idec (.inst(ir), .dec(dec));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RST;
      ir    <= RESET_INST;
      taken <= 1'b0;
      halt  <= 1'b0;
      trap  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_F_WAIT && ifu_rsp_valid_i) begin
        if (ifu_rsp_err_i) trap <= 1'b1;
        else               ir   <= ifu_rsp_inst_i;
      end
      if (state == S_DEC && dec.illegal) trap <= 1'b1;
      if (state == S_DEC && dec.ebreak)  halt <= 1'b1;
      if (state == S_EXE)                taken <= branch_taken_i;
    end
  end

  // Decoded fields are presented from DEC through WB and forced low elsewhere.
  assign dec_act = (state == S_DEC) || (state == S_EXE) || (state == S_M_REQ) ||
                   (state == S_M_WAIT) || (state == S_WB);

  always_comb begin
    state_nx        = state;
    ifu_req_valid_o = 1'b0;
    lsu_req_valid_o = 1'b0;
    lsu_we_o        = 1'b0;
    lsu_size_o      = 2'b00;
    imm_type_o      = IMM_NONE;
    alu_op_o        = 4'd0;
    alu_srca_pc_o   = 1'b0;
    alu_srcb_imm_o  = 1'b0;
    rf_we_o         = 1'b0;
    wb_sel_o        = WB_ALU;
    pc_we_o         = 1'b0;
    pc_sel_o        = PC_SEL_PC4;
    if (dec_act) begin
      imm_type_o     = dec.imm_type;
      alu_op_o       = dec.alu_op;
      alu_srca_pc_o  = dec.srca_pc;
      alu_srcb_imm_o = dec.srcb_imm;
      wb_sel_o       = dec.wb_sel;
      lsu_size_o     = dec.is_mem ? ir[13:12] : 2'b00;
    end
    case (state)
      S_RST:    state_nx = S_F_REQ;
      S_F_REQ: begin
        ifu_req_valid_o = 1'b1;
        if (ifu_req_ready_i) state_nx = S_F_WAIT;
      end
      S_F_WAIT: if (ifu_rsp_valid_i) state_nx = ifu_rsp_err_i ? S_HALT : S_DEC;
      S_DEC:    state_nx = (dec.illegal || dec.ebreak) ? S_HALT : S_EXE;
      S_EXE:    state_nx = dec.is_mem ? S_M_REQ : S_WB;
      S_M_REQ: begin
        lsu_req_valid_o = 1'b1;
        lsu_we_o        = dec.is_store;
        if (lsu_req_ready_i) state_nx = S_M_WAIT;
      end
      S_M_WAIT: if (lsu_rsp_valid_i) state_nx = S_WB;
      S_WB: begin
        pc_we_o = 1'b1;
        rf_we_o = dec.rf_we;
        case (dec.pc_kind)
          PK_JAL:  pc_sel_o = PC_SEL_IMM;
          PK_BR:   pc_sel_o = taken ? PC_SEL_IMM : PC_SEL_PC4;
          PK_JALR: pc_sel_o = PC_SEL_ALU;
          default: pc_sel_o = PC_SEL_PC4;
        endcase
        state_nx = S_F_REQ;
      end
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_RST;
    endcase
  end

  assign inst_o = ir;
  assign halt_o = halt;
  assign trap_o = trap;

endmodule

// File: tb/tb_ysyx_25040101_mc_ctrl.sv
// Randomized bench for the multi-cycle controller with a per-instruction behavioural model.
module tb_ysyx_25040101_mc_ctrl;

  localparam logic [31:0] RST_IR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, ifu_req_valid_o, ifu_req_ready_i, ifu_rsp_valid_i, ifu_rsp_err_i;
  logic [31:0] ifu_rsp_inst_i, inst_o;
  logic [4:0]  imm_type_o;
  logic [3:0]  alu_op_o;
  logic        alu_srca_pc_o, alu_srcb_imm_o, branch_taken_i;
  logic        lsu_req_valid_o, lsu_req_ready_i, lsu_we_o, lsu_rsp_valid_i;
  logic [1:0]  lsu_size_o, wb_sel_o, pc_sel_o;
  logic        rf_we_o, pc_we_o, halt_o, trap_o;

  always #5 clk = ~clk;

  ysyx_25040101_mc_ctrl #(.RESET_INST(RST_IR)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid_o(ifu_req_valid_o), .ifu_req_ready_i(ifu_req_ready_i),
    .ifu_rsp_valid_i(ifu_rsp_valid_i), .ifu_rsp_inst_i(ifu_rsp_inst_i),
    .ifu_rsp_err_i(ifu_rsp_err_i), .inst_o(inst_o), .imm_type_o(imm_type_o),
    .alu_op_o(alu_op_o), .alu_srca_pc_o(alu_srca_pc_o), .alu_srcb_imm_o(alu_srcb_imm_o),
    .branch_taken_i(branch_taken_i), .lsu_req_valid_o(lsu_req_valid_o),
    .lsu_req_ready_i(lsu_req_ready_i), .lsu_we_o(lsu_we_o), .lsu_size_o(lsu_size_o),
    .lsu_rsp_valid_i(lsu_rsp_valid_i), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
    .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .halt_o(halt_o), .trap_o(trap_o)
  );

  // What an instruction means, straight from the opcode table.
  typedef struct packed {
    logic [4:0] imm;
    logic       srca, srcb, rfw;
    logic [1:0] wb, size, pck;   // pck: 0 seq, 1 jal, 2 branch, 3 jalr
    logic       mem, st, bad, ebk;
  } md_t;

  typedef struct packed {
    logic        chk, act, req, lsu_v, lsu_we, rf_we, pc_we, srca, srcb, halt, trap;
    logic [1:0]  pc_sel, wb_sel, size;
    logic [4:0]  imm;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp;
  int          n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] m_ir;
  logic        m_halt, m_trap;
  int          rise_q[$];
  logic        prev_req = 1'b0;
  logic [4:0]  cap_imm;
  logic [1:0]  cap_pcsel, cap_wbsel, cap_size;
  logic        cap_rfwe, cap_lsuwe;
  int          cap_lsu_cnt;

  function automatic md_t mdec(input logic [31:0] w);
    md_t d = '0;
    case (w[6:0])
      7'b0110111: begin d.imm = 5'b00010; d.rfw = 1; end
      7'b0010111: begin d.imm = 5'b00010; d.srca = 1; d.rfw = 1; end
      7'b1101111: begin d.imm = 5'b00001; d.srca = 1; d.rfw = 1; d.wb = 2; d.pck = 1; end
      7'b1100111: begin d.imm = 5'b10000; d.rfw = 1; d.wb = 2; d.pck = 3; end
      7'b1100011: begin d.imm = 5'b00100; d.pck = 2; end
      7'b0000011: begin d.imm = 5'b10000; d.rfw = 1; d.wb = 1; d.mem = 1; d.size = w[13:12]; end
      7'b0100011: begin d.imm = 5'b01000; d.mem = 1; d.st = 1; d.size = w[13:12]; end
      7'b0010011: begin d.imm = 5'b10000; d.rfw = 1; end
      7'b0110011: d.rfw = 1;
      7'b1110011: begin d.imm = 5'b10000; d.ebk = (w == 32'h0010_0073); end
      default:    d.bad = 1;
    endcase
    // Any instruction carrying an immediate feeds it to ALU B, except branches (rs1 vs rs2).
    d.srcb = (d.imm != 5'b0) && (d.pck != 2);
    return d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifu_req_valid_o === 1'b1 && !prev_req) rise_q.push_back(cyc);
    prev_req = (ifu_req_valid_o === 1'b1);
    if (exp.chk) begin
      chk("ifu_req_valid", ifu_req_valid_o, exp.req);
      chk("lsu_req_valid", lsu_req_valid_o, exp.lsu_v);
      chk("lsu_we", lsu_we_o, exp.lsu_we);
      chk("lsu_size", lsu_size_o, exp.size);
      chk("rf_we", rf_we_o, exp.rf_we);
      chk("pc_we", pc_we_o, exp.pc_we);
      chk("pc_sel", pc_sel_o, exp.pc_sel);
      chk("wb_sel", wb_sel_o, exp.wb_sel);
      chk("imm_type", imm_type_o, exp.imm);
      chk("srca_pc", alu_srca_pc_o, exp.srca);
      chk("srcb_imm", alu_srcb_imm_o, exp.srcb);
      chk("halt", halt_o, exp.halt);
      chk("trap", trap_o, exp.trap);
      chk("inst", inst_o, exp.inst);
      if (!exp.act) chk("alu_op idle", alu_op_o, 0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic base();
    exp = '0;
    exp.chk = 1; exp.inst = m_ir; exp.halt = m_halt; exp.trap = m_trap;
    rst_n = 1; ifu_req_ready_i = 0; ifu_rsp_valid_i = 0; ifu_rsp_err_i = 0;
    ifu_rsp_inst_i = $urandom; lsu_req_ready_i = 0; lsu_rsp_valid_i = 0;
    branch_taken_i = 1'($urandom_range(0, 1));
  endtask

  task automatic act(input md_t d);
    exp.act = 1; exp.imm = d.imm; exp.srca = d.srca; exp.srcb = d.srcb;
    exp.wb_sel = d.wb; exp.size = d.size;
  endtask

  task automatic do_reset();
    base(); exp.chk = 0; rst_n = 0; step();
    m_ir = RST_IR; m_halt = 0; m_trap = 0;
    base(); step();   // RST cycle: everything low
  endtask

  task automatic halt_idle(input int n);
    for (int k = 0; k < n; k++) begin
      base();
      ifu_req_ready_i = 1'($urandom_range(0, 1)); ifu_rsp_valid_i = 1'($urandom_range(0, 1));
      lsu_req_ready_i = 1'($urandom_range(0, 1)); lsu_rsp_valid_i = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  // Walk one instruction from F_REQ; the bench chooses every handshake delay.
  task automatic run_inst(input logic [31:0] w, input logic tk, input int rd, input int pd,
                          input int lrd, input int lpd, input logic err, input logic abort);
    md_t d = mdec(w);
    for (int k = 0; k <= rd; k++) begin
      base(); exp.req = 1; ifu_req_ready_i = (k == rd);
      ifu_rsp_valid_i = 1'($urandom_range(0, 1)); ifu_rsp_err_i = 1'($urandom_range(0, 1));
      step();
    end
    for (int k = 0; k <= pd; k++) begin
      base(); ifu_rsp_valid_i = (k == pd);
      if (k == pd) begin ifu_rsp_inst_i = w; ifu_rsp_err_i = err; end
      else ifu_rsp_err_i = 1'($urandom_range(0, 1));
      step();
    end
    if (err) begin m_trap = 1; return; end
    m_ir = w;
    base(); act(d); #3 cap_imm = imm_type_o; step();
    if (d.bad) begin m_trap = 1; return; end
    if (d.ebk) begin m_halt = 1; return; end
    base(); act(d); branch_taken_i = tk; step();
    cap_lsu_cnt = 0; cap_lsuwe = 0;
    if (d.mem) begin
      for (int k = 0; k <= lrd; k++) begin
        base(); act(d); exp.lsu_v = 1; exp.lsu_we = d.st; lsu_req_ready_i = (k == lrd);
        #3 cap_lsu_cnt += int'(lsu_req_valid_o); cap_lsuwe = lsu_we_o; cap_size = lsu_size_o;
        step();
      end
      for (int k = 0; k <= lpd; k++) begin
        base(); act(d);
        if (abort) begin
          rst_n = 0; step();
          m_ir = RST_IR; m_halt = 0; m_trap = 0;
          base(); step();
          return;
        end
        lsu_rsp_valid_i = (k == lpd); step();
      end
    end
    base(); act(d); exp.pc_we = 1; exp.rf_we = d.rfw;
    exp.pc_sel = (d.pck == 1) ? 2'b01 : (d.pck == 3) ? 2'b10 : (d.pck == 2 && tk) ? 2'b01 : 2'b00;
    #3 cap_pcsel = pc_sel_o; cap_rfwe = rf_we_o; cap_wbsel = wb_sel_o;
    step();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 15))
      0:  w[6:0] = 7'b0110111;
      1:  w[6:0] = 7'b0010111;
      2:  w[6:0] = 7'b1101111;
      3:  w[6:0] = 7'b1100111;
      4, 5: w[6:0] = 7'b1100011;
      6, 7: w[6:0] = 7'b0000011;
      8:  w[6:0] = 7'b0100011;
      9, 10: w[6:0] = 7'b0010011;
      11: w[6:0] = 7'b0110011;
      12: w[6:0] = 7'b1110011;
      13: w = 32'h0010_0073;
      14: w[1:0] = 2'($urandom_range(0, 2));
      default: w[6:0] = 7'b0001111;
    endcase
    return w;
  endfunction

  initial begin
    int r0;
    logic [31:0] w;
    m_ir = RST_IR; m_halt = 0; m_trap = 0;
    base(); exp.chk = 0; rst_n = 0;
    step(); step();
    m_ir = RST_IR;
    base(); step();   // RST cycle
    chk("reset inst_o", inst_o, RST_IR);

    // addi back-to-back, zero wait states: fetch requests 5 cycles apart
    rise_q.delete();
    run_inst(32'h00500093, 0, 0, 0, 0, 0, 0, 0);
    chk("addi imm_type", cap_imm, 5'b10000);
    chk("addi rf_we", cap_rfwe, 1);
    chk("addi pc_sel", cap_pcsel, 2'b00);
    run_inst(32'h00500093, 0, 0, 0, 0, 0, 0, 0);
    chk("fetch gap", (rise_q.size() >= 2) ? rise_q[1] - rise_q[0] : -1, 5);

    run_inst(32'h00208463, 1, 1, 0, 0, 0, 0, 0);
    chk("beq imm_type", cap_imm, 5'b00100);
    chk("beq taken pc_sel", cap_pcsel, 2'b01);
    chk("beq rf_we", cap_rfwe, 0);
    run_inst(32'h00208463, 0, 0, 2, 0, 0, 0, 0);
    chk("beq not-taken pc_sel", cap_pcsel, 2'b00);

    run_inst(32'h0000a103, 0, 0, 0, 3, 1, 0, 0);
    chk("load req cycles", cap_lsu_cnt, 4);
    chk("load we", cap_lsuwe, 0);
    chk("load size", cap_size, 2'b10);
    chk("load wb_sel", cap_wbsel, 2'b01);
    run_inst(32'h0020a023, 0, 0, 0, 0, 0, 0, 0);
    chk("store imm_type", cap_imm, 5'b01000);
    chk("store we", cap_lsuwe, 1);
    chk("store rf_we", cap_rfwe, 0);

    run_inst(32'h008000ef, 0, 0, 0, 0, 0, 0, 0);
    chk("jal imm_type", cap_imm, 5'b00001);
    chk("jal wb_sel", cap_wbsel, 2'b10);
    chk("jal pc_sel", cap_pcsel, 2'b01);
    run_inst(32'h000080e7, 0, 0, 0, 0, 0, 0, 0);
    chk("jalr imm_type", cap_imm, 5'b10000);
    chk("jalr pc_sel", cap_pcsel, 2'b10);
    run_inst(32'h123450b7, 0, 0, 0, 0, 0, 0, 0);
    chk("lui imm_type", cap_imm, 5'b00010);
    chk("lui rf_we", cap_rfwe, 1);

    run_inst(32'hffffffff, 0, 0, 0, 0, 0, 0, 0);
    r0 = rise_q.size();
    halt_idle(6);
    chk("illegal trap", trap_o, 1);
    chk("illegal halt", halt_o, 0);
    chk("illegal no refetch", rise_q.size(), r0);
    do_reset();
    run_inst(32'h00100073, 0, 0, 0, 0, 0, 0, 0);
    r0 = rise_q.size();
    halt_idle(6);
    chk("ebreak halt", halt_o, 1);
    chk("ebreak trap", trap_o, 0);
    chk("ebreak no refetch", rise_q.size(), r0);
    do_reset();
    run_inst(32'h00500093, 0, 0, 1, 0, 0, 1, 0);
    halt_idle(3);
    chk("fetch err trap", trap_o, 1);
    do_reset();
    run_inst(32'h0000a103, 0, 0, 0, 0, 2, 0, 1);
    chk("abort inst_o", inst_o, RST_IR);
    chk("abort refetch", ifu_req_valid_o, 1);

    for (int i = 0; i < 300; i++) begin
      w = rand_inst();
      run_inst(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 29) == 0));
      if (m_halt || m_trap) begin halt_idle(2); do_reset(); end
    end

    exp.chk = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
